// File: rtl/dtc_cmd_regfile.sv
// DTC command register file: decodes slave-bus register accesses for the FEC control logic.
// Define DTC_CMD_ACCESS_ERR_EN to add the saturating access-error counter at 0x82.
module dtc_cmd_regfile #(
    parameter int NUM_CH    = 64,
    parameter int NUM_HV    = 32,
    parameter int NUM_ADC   = 15,
    parameter int PWR_W     = 11,
    parameter int PULSE_LEN = 4
) (
    input  logic                  dtc_clk,
    input  logic                  rst,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    input  logic                  write,
    input  logic                  read,
    output logic [31:0]           read_data,
    output logic                  data_vld,
    output logic [PWR_W-1:0]      reg_pwr_en,
    input  logic [15:0]           status,
    output logic [7:0]            thyst,
    output logic [7:0]            toti,
    output logic [NUM_CH-1:0]     channel_mask,
    output logic                  altro_rst,
    output logic                  fee_rst,
    input  logic [15:0]           firmware,
    input  logic [NUM_ADC*10-1:0] adc_data,
    output logic [NUM_HV*12-1:0]  hv_dac_data,
    output logic                  hv_busy,
    output logic                  hv_vld,
    input  logic                  hv_rdy,
    output logic [4:0]            hv_ch,
    output logic [11:0]           hv_val
);
    localparam int MASK_REGS = NUM_CH / 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [7:0]  addr;
    logic [4:0]  map_address;
    logic [15:0] serial;
    logic        serial_locked;
    logic [7:0]  altro_cnt;
    logic [7:0]  fee_cnt;
    logic [1:0]  state;
    logic [4:0]  idx;
    logic        hv_done;
    logic [11:0] hv_reg [NUM_HV];
    logic [31:0] rd_mux;
    logic        rd_err;
    logic        unused_wdata;
`ifdef DTC_CMD_ACCESS_ERR_EN
    logic [15:0] err_cnt;
`endif

    assign addr         = address[7:0];
    assign unused_wdata = ^write_data[31:16];
    assign altro_rst    = (altro_cnt != 8'd0);
    assign fee_rst      = (fee_cnt != 8'd0);
    assign hv_busy      = (state != ST_IDLE);
    assign hv_vld       = (state == ST_SEND);
    assign hv_ch        = idx;

    for (genvar i = 0; i < NUM_HV; i++) begin : g_dac
        assign hv_dac_data[12*i +: 12] = hv_reg[i];
    end

    always_comb begin
        hv_val = 12'd0;
        for (int i = 0; i < NUM_HV; i++)
            if (idx == 5'(i)) hv_val = hv_reg[i];
    end

    // Unmapped reads (including out-of-range indices) echo the full address.
    always_comb begin
        // NOTE: defaults first so every path assigns; a missing default would infer a latch.
        rd_mux = address;
        rd_err = 1'b1;
        case (addr)
            8'h01: begin rd_mux = 32'(reg_pwr_en);              rd_err = 1'b0; end
            8'h02: begin rd_mux = {16'b0, status};              rd_err = 1'b0; end
            8'h03: begin rd_mux = {27'b0, map_address};         rd_err = 1'b0; end
            8'h04: begin rd_mux = {24'b0, thyst};               rd_err = 1'b0; end
            8'h05: begin rd_mux = {24'b0, toti};                rd_err = 1'b0; end
            8'h1F: begin rd_mux = {30'b0, hv_done, hv_busy};    rd_err = 1'b0; end
            8'h20: begin rd_mux = {16'b0, firmware};            rd_err = 1'b0; end
            8'h80: begin rd_mux = {16'b0, serial};              rd_err = 1'b0; end
            8'h81: begin rd_mux = {31'b0, serial_locked};       rd_err = 1'b0; end
`ifdef DTC_CMD_ACCESS_ERR_EN
            8'h82: begin rd_mux = {16'b0, err_cnt};             rd_err = 1'b0; end
`endif
            default: ;
        endcase
        for (int k = 0; k < MASK_REGS; k++)
            if (addr == 8'(8'h06 + k)) begin
                rd_mux = {16'b0, channel_mask[16*k +: 16]};
                rd_err = 1'b0;
            end
        for (int k = 0; k < NUM_ADC; k++)
            if (addr == 8'(8'h50 + k)) begin
                rd_mux = {22'b0, adc_data[10*k +: 10]};
                rd_err = 1'b0;
            end
        for (int i = 0; i < NUM_HV; i++)
            if (addr == 8'(8'h60 + i)) begin
                rd_mux = {20'b0, hv_reg[i]};
                rd_err = 1'b0;
            end
    end

    always_ff @(posedge dtc_clk or posedge rst) begin
        if (rst) begin
            read_data     <= '0;
            data_vld      <= 1'b0;
            reg_pwr_en    <= '0;
            map_address   <= '0;
            thyst         <= '0;
            toti          <= '0;
            channel_mask  <= '0;
            serial        <= '0;
            serial_locked <= 1'b0;
            altro_cnt     <= '0;
            fee_cnt       <= '0;
            state         <= ST_IDLE;
            idx           <= '0;
            hv_done       <= 1'b0;
            // NOTE: setpoints are reset too, so this array is registers, not a reset-less RAM.
            for (int i = 0; i < NUM_HV; i++) hv_reg[i] <= '0;
        end else begin
            // NOTE: non-blocking everywhere, so a read colliding with a write sees the old value.
            data_vld <= read;
            if (read) read_data <= rd_mux;
            if (altro_rst) altro_cnt <= altro_cnt - 8'd1;
            if (fee_rst)   fee_cnt   <= fee_cnt - 8'd1;

            if (write) begin
                case (addr)
                    8'h01: reg_pwr_en  <= write_data[PWR_W-1:0];
                    8'h03: map_address <= write_data[4:0];
                    8'h04: thyst       <= write_data[7:0];
                    8'h05: toti        <= write_data[7:0];
                    8'h19: altro_cnt   <= 8'(PULSE_LEN);
                    8'h1A: fee_cnt     <= 8'(PULSE_LEN);
                    8'h80: if (!serial_locked) begin
                        serial        <= write_data[15:0];
                        serial_locked <= 1'b1;
                    end
                    default: ;
                endcase
                for (int k = 0; k < MASK_REGS; k++)
                    if (addr == 8'(8'h06 + k)) channel_mask[16*k +: 16] <= write_data[15:0];
                // Setpoints are frozen while the sequencer streams them out.
                for (int i = 0; i < NUM_HV; i++)
                    if (!hv_busy && addr == 8'(8'h60 + i)) hv_reg[i] <= write_data[11:0];
            end

            case (state)
                ST_IDLE: if (write && addr == 8'h1E) begin
                    state   <= ST_SEND;
                    idx     <= '0;
                    hv_done <= 1'b0;
                end
                ST_SEND: if (hv_rdy) begin
                    if (idx == 5'(NUM_HV - 1)) state <= ST_DONE;
                    else                       idx   <= idx + 5'd1;
                end
                ST_DONE: begin
                    hv_done <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DTC_CMD_ACCESS_ERR_EN
    logic        wr_hit;
    logic        wr_drop;
    logic [16:0] err_sum;

    always_comb begin
        wr_hit  = 1'b0;
        wr_drop = 1'b0;
        case (addr)
            8'h01, 8'h03, 8'h04, 8'h05, 8'h19, 8'h1A, 8'h82: wr_hit = 1'b1;
            8'h1E: begin wr_hit = 1'b1; wr_drop = hv_busy;       end
            8'h80: begin wr_hit = 1'b1; wr_drop = serial_locked; end
            default: ;
        endcase
        for (int k = 0; k < MASK_REGS; k++)
            if (addr == 8'(8'h06 + k)) wr_hit = 1'b1;
        for (int i = 0; i < NUM_HV; i++)
            if (addr == 8'(8'h60 + i)) begin
                wr_hit  = 1'b1;
                wr_drop = hv_busy;
            end
    end

    assign err_sum = {1'b0, err_cnt} + 17'(read && rd_err) + 17'(write && (!wr_hit || wr_drop));

    always_ff @(posedge dtc_clk or posedge rst) begin
        if (rst)                          err_cnt <= '0;
        else if (write && addr == 8'h82)  err_cnt <= 16'(read && rd_err);
        else                              err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`else
    logic unused_rd_err;
    assign unused_rd_err = rd_err;
`endif
endmodule
